// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, one-cycle registered
// instruction memory interface, redirect handling and misaligned-target trap.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 11
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] imaddr,
    output logic             imce,
    input  logic [31:0]      inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             id_exc
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_nxt;
    logic        r_req_valid;
    logic        w_req_valid_nxt;
    logic        r_exc;
    logic        w_exc_nxt;
    logic        w_fetch;

    // State register: reset forces RUN with an empty request slot.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_req_pc    <= 32'h0000_0000;
            r_req_valid <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_exc       <= w_exc_nxt;
        end
    end

    // Next-state logic: redirect outranks stall; a misaligned target parks in HALT.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_pc_nxt    = r_req_pc;
        w_req_valid_nxt = r_req_valid;
        w_exc_nxt       = r_exc;
        w_fetch         = 1'b0;
        if (redirect) begin
            w_req_valid_nxt = 1'b0;
            w_exc_nxt       = 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                w_pc_nxt    = redirect_pc;
                w_state_nxt = ST_RUN;
            end else begin
                w_req_pc_nxt    = redirect_pc;
                w_req_valid_nxt = 1'b1;
                w_exc_nxt       = 1'b1;
                w_state_nxt     = ST_HALT;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        w_fetch         = 1'b1;
                        w_req_pc_nxt    = r_pc;
                        w_req_valid_nxt = 1'b1;
                        w_exc_nxt       = 1'b0;
                        w_pc_nxt        = r_pc + 32'd4;
                    end else begin
                        w_fetch = 1'b0;
                    end
                end
                ST_HALT: begin
                    w_fetch = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Gating with reset keeps the memory idle while reset is held.
    assign imce     = w_fetch & cpu_rst_n;
    assign imaddr   = r_pc[IM_AW+1:2];
    assign id_valid = r_req_valid;
    assign id_pc    = r_req_pc;
    assign id_exc   = r_exc;
    assign id_inst  = r_exc ? 32'h0000_0000 : inst;

endmodule
